// File: rtl/button_pulser.sv
// ---------------------------------------------------------------------------
// button_pulser
//   Debounces a raw push-button and produces single-cycle strobes. One
//   strobe fires on a confirmed press. While the button stays held and
//   auto-repeat is on, further strobes fire after an initial delay and then
//   at a fixed period. All state changes on the falling edge of NEclk.
//
// Parameters
//   DEB_CYCLES    debounce length in clock cycles (>= 1)
//   REPEAT_DELAY  cycles from the press strobe to the first repeat strobe (>= 1)
//   REPEAT_PERIOD cycles between repeat strobes (>= 1)
//   CNT_BITS      counter width; must hold max(parameters) - 1
//
// Ports
//   NEclk   in   clock, falling-edge active
//   Nreset  in   synchronous reset, active-low
//   btn     in   raw asynchronous button level, active-high
//   Enable  in   strobe gate; forces pulse low without stalling the FSM
//   rep_en  in   auto-repeat enable
//   pulse   out  registered single-cycle strobe
//   held    out  registered debounced button level
//   state   out  current FSM state (debug)
// ---------------------------------------------------------------------------
module button_pulser #(
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_BITS      = 25
) (
  input  logic       NEclk,
  input  logic       Nreset,
  input  logic       btn,
  input  logic       Enable,
  input  logic       rep_en,
  output logic       pulse,
  output logic       held,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DEB_P  = 3'd1,
    HELD   = 3'd2,
    REPEAT = 3'd3,
    DEB_R  = 3'd4
  } state_t;

  localparam logic [CNT_BITS-1:0] DEB_LAST = CNT_BITS'(DEB_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] RD_LAST  = CNT_BITS'(REPEAT_DELAY - 1);
  localparam logic [CNT_BITS-1:0] RP_LAST  = CNT_BITS'(REPEAT_PERIOD - 1);
  localparam logic [CNT_BITS-1:0] ONE      = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] ZERO     = '0;

  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_BITS-1:0] rcnt_q, rcnt_d;
  logic                pulse_q, pulse_d;
  logic                held_q, held_d;
  logic                fire;

  // Two-flop synchronizer; the FSM only ever looks at s2.
  always_comb begin
    s1_d = btn;
    s2_d = s1_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    fire    = 1'b0;

    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = DEB_P;
          cnt_d   = ZERO;
        end
      end

      DEB_P: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          fire    = 1'b1;
          rcnt_d  = ZERO;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      HELD: begin
        if (!s2_q) begin
          state_d = DEB_R;
          cnt_d   = ZERO;
        end else if (rep_en) begin
          if (rcnt_q == RD_LAST) begin
            state_d = REPEAT;
            fire    = 1'b1;
            rcnt_d  = ZERO;
          end else if (rcnt_q > RD_LAST) begin
            // A count carried back from REPEAT can exceed the delay limit;
            // clamp so the next edge still fires instead of stalling.
            rcnt_d = RD_LAST;
          end else begin
            rcnt_d = rcnt_q + ONE;
          end
        end
        // rep_en low: rcnt holds so repeating resumes where it paused.
      end

      REPEAT: begin
        if (!s2_q) begin
          state_d = DEB_R;
          cnt_d   = ZERO;
        end else if (!rep_en) begin
          state_d = HELD;
        end else if (rcnt_q >= RP_LAST) begin
          fire   = 1'b1;
          rcnt_d = ZERO;
        end else begin
          rcnt_d = rcnt_q + ONE;
        end
      end

      DEB_R: begin
        if (s2_q) begin
          // Release glitch: back to held, restarting the repeat delay.
          state_d = HELD;
          rcnt_d  = ZERO;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Gate only the strobe; the FSM keeps running when Enable is low, and a
  // suppressed strobe is simply lost.
  always_comb begin
    pulse_d = fire & Enable;
    held_d  = (state_d == HELD) || (state_d == REPEAT) || (state_d == DEB_R);
  end

  always_ff @(negedge NEclk) begin
    if (!Nreset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= ZERO;
      rcnt_q  <= ZERO;
      pulse_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
    end
  end

  assign pulse = pulse_q;
  assign held  = held_q;
  assign state = state_q;

endmodule

// File: tb/tb_button_pulser.sv
// ---------------------------------------------------------------------------
// tb_button_pulser
//   Table-driven bench for button_pulser with DEB_CYCLES=4, REPEAT_DELAY=10,
//   REPEAT_PERIOD=3, CNT_BITS=4. Each vector is one falling clock edge: the
//   inputs applied before that edge and the pulse/held/state expected just
//   after it. Edge numbers restart at 0 on the first edge after reset.
// ---------------------------------------------------------------------------
module tb_button_pulser;

  typedef struct {
    logic       btn;
    logic       en;
    logic       rep;
    logic       nrst;
    logic       exp_pulse;
    logic       exp_held;
    logic [2:0] exp_state;
    int         scen;
    int         edge_no;
  } vec_t;

  logic       clk;
  logic       nreset;
  logic       btn;
  logic       enable;
  logic       rep_en;
  logic       pulse;
  logic       held;
  logic [2:0] state;

  int   pass_cnt;
  int   total_cnt;
  vec_t vecs[$];

  button_pulser #(
    .DEB_CYCLES    (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3),
    .CNT_BITS      (4)
  ) dut (
    .NEclk  (clk),
    .Nreset (nreset),
    .btn    (btn),
    .Enable (enable),
    .rep_en (rep_en),
    .pulse  (pulse),
    .held   (held),
    .state  (state)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic void add(input logic b, input logic en, input logic rp,
                              input logic nr, input logic ep, input logic eh,
                              input logic [2:0] es, input int sc, input int e);
    vec_t v;
    v.btn = b;  v.en = en;  v.rep = rp;  v.nrst = nr;
    v.exp_pulse = ep;  v.exp_held = eh;  v.exp_state = es;
    v.scen = sc;  v.edge_no = e;
    vecs.push_back(v);
  endfunction

  function automatic void add_reset(input int sc);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, sc, -1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, sc, -1);
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s vec %0d scen %0d edge %0d: got %0d expected %0d",
                  name, idx, vecs[idx].scen, vecs[idx].edge_no, act, exp);
  endtask

  initial begin
    int bp[6] = '{1, 1, 0, 1, 1, 0};
    logic [2:0] st;

    pass_cnt  = 0;
    total_cnt = 0;

    // Scenario 1: clean press, release after edge 12.
    add_reset(1);
    for (int e = 0; e <= 22; e++) begin
      st = (e < 2) ? 3'd0 : (e < 6) ? 3'd1 : (e < 15) ? 3'd2 : (e < 19) ? 3'd4 : 3'd0;
      add(e <= 12, 1'b1, 1'b1, 1'b1, e == 6, (e >= 6) && (e < 19), st, 1, e);
    end

    // Scenario 2: bounce 1,1,0,1,1,0 then low.
    add_reset(2);
    for (int e = 0; e <= 11; e++) begin
      st = (e == 2 || e == 3 || e == 5 || e == 6) ? 3'd1 : 3'd0;
      add((e < 6) ? bp[e][0] : 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, st, 2, e);
    end

    // Scenario 3: long hold with auto-repeat, then reset mid-repeat.
    add_reset(3);
    for (int e = 0; e <= 26; e++) begin
      st = (e < 2) ? 3'd0 : (e < 6) ? 3'd1 : (e < 16) ? 3'd2 : 3'd3;
      add(1'b1, 1'b1, 1'b1, 1'b1,
          (e == 6) || (e == 16) || (e == 19) || (e == 22) || (e == 25),
          e >= 6, st, 3, e);
    end
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3, 27);
    for (int r = 0; r <= 8; r++) begin
      st = (r < 2) ? 3'd0 : (r < 6) ? 3'd1 : 3'd2;
      add(1'b1, 1'b1, 1'b1, 1'b1, r == 6, r >= 6, st, 3, 100 + r);
    end

    // Scenario 4: clean press with Enable low.
    add_reset(4);
    for (int e = 0; e <= 22; e++) begin
      st = (e < 2) ? 3'd0 : (e < 6) ? 3'd1 : (e < 15) ? 3'd2 : (e < 19) ? 3'd4 : 3'd0;
      add(e <= 12, 1'b0, 1'b1, 1'b1, 1'b0, (e >= 6) && (e < 19), st, 4, e);
    end

    // Scenario 5: release glitch of two edges while held.
    add_reset(5);
    for (int e = 0; e <= 23; e++) begin
      st = (e < 2) ? 3'd0 : (e < 6) ? 3'd1 : (e < 10) ? 3'd2 :
           (e < 12) ? 3'd4 : (e < 22) ? 3'd2 : 3'd3;
      add((e <= 7) || (e >= 10), 1'b1, 1'b1, 1'b1, (e == 6) || (e == 22),
          e >= 6, st, 5, e);
    end

    // Scenario 6: hold with rep_en low (count frozen), enable repeat at edge 21.
    add_reset(6);
    for (int e = 0; e <= 31; e++) begin
      st = (e < 2) ? 3'd0 : (e < 6) ? 3'd1 : (e < 30) ? 3'd2 : 3'd3;
      add(1'b1, 1'b1, e >= 21, 1'b1, (e == 6) || (e == 30), e >= 6, st, 6, e);
    end

    btn = 1'b0; enable = 1'b1; rep_en = 1'b1; nreset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      btn    = vecs[i].btn;
      enable = vecs[i].en;
      rep_en = vecs[i].rep;
      nreset = vecs[i].nrst;
      @(negedge clk);
      #2;
      $display("vec %0d scen %0d edge %0d btn=%b en=%b rep=%b nrst=%b -> pulse=%b held=%b state=%0d",
               i, vecs[i].scen, vecs[i].edge_no, btn, enable, rep_en, nreset,
               pulse, held, state);
      check("pulse", i, int'(pulse), int'(vecs[i].exp_pulse));
      check("held",  i, int'(held),  int'(vecs[i].exp_held));
      check("state", i, int'(state), int'(vecs[i].exp_state));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
